// File: rtl/ascii_save_buffer_pkg.sv
// -----------------------------------------------------------------------------
// uk101_save_pkg
// Shared types and constants for the ACIA transmit capture buffer
// (ascii_save_buffer) and its RAM (save_ram).
//   state_t   : capture FSM states
//   rd_sel_t  : source of the ioctl read data register
//   CHR_*     : control characters used by the optional CR/LF filter
// -----------------------------------------------------------------------------
package uk101_save_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PAUSE   = 2'd2,
    LF_PEND = 2'd3
  } state_t;

  // RD_NONE only exists between reset and the first read so that
  // ioctl_din comes out of reset as zero regardless of PAD_BYTE.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_PAD  = 2'd1,
    RD_RAM  = 2'd2
  } rd_sel_t;

  localparam logic [7:0] CHR_NUL = 8'h00;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_CR  = 8'h0D;

endpackage

// File: rtl/ascii_save_buffer_save_ram.sv
// -----------------------------------------------------------------------------
// save_ram
// Simple dual-port byte RAM: one write port, one registered read port with
// one clock of latency. No reset on the array or read register so that the
// block maps onto M10K.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; q only changes on a read
//   raddr  : read address
//   q      : registered read data
// -----------------------------------------------------------------------------
module save_ram #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        q
);

  logic [7:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/ascii_save_buffer.sv
// -----------------------------------------------------------------------------
// ascii_save_buffer
// Captures every byte the UK101 ACIA transmits while capture is armed and
// serves the captured bytes to the HPS through the ioctl upload interface.
//
// Parameters
//   ADDR_W    : buffer address width, capacity 2**ADDR_W bytes (max 15)
//   PAD_BYTE  : value returned for reads at or beyond byte_count
//
// Ports
//   clk          : system clock
//   n_reset      : asynchronous active-low reset
//   capture_en   : level; rising edge arms a fresh capture, falling ends it
//   tx_strobe    : one-cycle pulse when the ACIA transmit register is loaded
//   tx_data      : byte written to the ACIA transmit register
//   ioctl_upload : high while the HPS is uploading (pauses capture)
//   ioctl_rd     : one-cycle read request
//   ioctl_addr   : byte address of the read
//   ioctl_din    : read data, valid one clock after ioctl_rd, then held
//   byte_count   : number of bytes captured (zero-extended write pointer)
//   overflow     : sticky, at least one byte dropped since last arm
//   capturing    : high while capture is active
//
// Build option
//   ASCII_SAVE_CRLF_EN : when defined, NULs are discarded, each CR is followed
//                        by an inserted LF, and an LF directly after a CR is
//                        discarded. When undefined bytes are stored verbatim.
// -----------------------------------------------------------------------------
module ascii_save_buffer #(
  parameter int unsigned ADDR_W   = 14,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        capture_en,
  input  logic        tx_strobe,
  input  logic [7:0]  tx_data,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [15:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic [15:0] byte_count,
  output logic        overflow,
  output logic        capturing
);

  import uk101_save_pkg::*;

  // wptr saturates at 2**ADDR_W, so it carries one extra bit.
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  state_t          state_nxt;
  logic            cap_q;
  logic            cap_prev;
  logic            rise;
  logic            fall;
  logic            arm;
  logic            accept;
  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] wptr_base;
  logic [ADDR_W:0] wptr_nxt;
  logic            wr_en;
  logic [7:0]      wr_data;
  logic            ovf_set;
  rd_sel_t         rd_sel;
  logic [7:0]      ram_q;

`ifdef ASCII_SAVE_CRLF_EN
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  logic last_cr;
  logic last_cr_eff;
  logic last_cr_nxt;
  logic lf_req;
`endif

  assign rise = cap_q & ~cap_prev;
  assign fall = ~cap_q & cap_prev;

  // An arm and a strobe in the same cycle: the pointer clear is applied
  // first (wptr_base) and the strobe is then accepted at address 0.
  always_comb begin
    arm       = (state == IDLE) && rise;
    accept    = (state == CAPTURE) || arm;
    wptr_base = arm ? '0 : wptr;
    wr_en     = 1'b0;
    wr_data   = tx_data;
    ovf_set   = 1'b0;

`ifdef ASCII_SAVE_CRLF_EN
    lf_req      = 1'b0;
    last_cr_eff = arm ? 1'b0 : last_cr;
    last_cr_nxt = last_cr_eff;

    if (state == LF_PEND) begin
      // Room for the LF was reserved when the CR was accepted.
      wr_en   = (wptr_base != FULL);
      wr_data = CHR_LF;
    end else if (tx_strobe && accept) begin
      if (tx_data != CHR_NUL) begin
        last_cr_nxt = (tx_data == CHR_CR);
      end
      if ((tx_data != CHR_NUL) && !((tx_data == CHR_LF) && last_cr_eff)) begin
        if (wptr_base == FULL) begin
          ovf_set = 1'b1;
        end else begin
          wr_en = 1'b1;
          if (tx_data == CHR_CR) begin
            if (wptr_base == LAST) begin
              ovf_set = 1'b1;
            end else begin
              lf_req = 1'b1;
            end
          end
        end
      end
    end
`else
    if (tx_strobe && accept) begin
      if (wptr_base == FULL) begin
        ovf_set = 1'b1;
      end else begin
        wr_en = 1'b1;
      end
    end
`endif

    if (tx_strobe && (state == PAUSE)) begin
      ovf_set = 1'b1;
    end

    wptr_nxt = wptr_base + {{ADDR_W{1'b0}}, wr_en};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rise) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (fall)              state_nxt = IDLE;
        else if (ioctl_upload) state_nxt = PAUSE;
      end
      PAUSE: begin
        // A capture_en fall during the upload shows up as a low level here.
        if (!ioctl_upload) state_nxt = cap_q ? CAPTURE : IDLE;
      end
      LF_PEND: begin
        if (!cap_q)            state_nxt = IDLE;
        else if (ioctl_upload) state_nxt = PAUSE;
        else                   state_nxt = CAPTURE;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef ASCII_SAVE_CRLF_EN
    // The inserted LF takes precedence; LF_PEND re-evaluates exit conditions.
    if (lf_req) state_nxt = LF_PEND;
`endif
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cap_q     <= 1'b0;
      cap_prev  <= 1'b0;
      state     <= IDLE;
      capturing <= 1'b0;
      wptr      <= '0;
      overflow  <= 1'b0;
      rd_sel    <= RD_NONE;
    end else begin
      cap_q     <= capture_en;
      cap_prev  <= cap_q;
      state     <= state_nxt;
      capturing <= (state_nxt == CAPTURE) || (state_nxt == LF_PEND);
      wptr      <= wptr_nxt;
      overflow  <= (overflow & ~arm) | ovf_set;
      if (ioctl_rd) begin
        rd_sel <= (ioctl_addr < 16'(wptr)) ? RD_RAM : RD_PAD;
      end
    end
  end

`ifdef ASCII_SAVE_CRLF_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      last_cr <= 1'b0;
    end else begin
      last_cr <= last_cr_nxt;
    end
  end
`endif

  assign byte_count = 16'(wptr);

  // ram_q and rd_sel only change on a read, so the output holds between reads.
  always_comb begin
    case (rd_sel)
      RD_RAM:  ioctl_din = ram_q;
      RD_PAD:  ioctl_din = PAD_BYTE;
      default: ioctl_din = '0;
    endcase
  end

  save_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_base[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (ioctl_rd),
    .raddr (ioctl_addr[ADDR_W-1:0]),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_ascii_save_buffer.sv
// -----------------------------------------------------------------------------
// tb_ascii_save_buffer
// Self-checking bench for ascii_save_buffer with a 16-byte buffer. A
// behavioural model (byte array, count, overflow flag, capture mode) tracks
// what the outputs must be; a compare process checks all outputs against it
// every settled cycle, and directed scenarios pin the model with literals.
// -----------------------------------------------------------------------------
module tb_ascii_save_buffer;

  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        n_reset = 1'b1;
  logic        capture_en = 1'b0;
  logic        tx_strobe = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [15:0] ioctl_addr = 16'h0000;
  logic [7:0]  ioctl_din;
  logic [15:0] byte_count;
  logic        overflow;
  logic        capturing;

  always #5 clk = ~clk;

  ascii_save_buffer #(
    .ADDR_W   (AW),
    .PAD_BYTE (8'h00)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .capture_en   (capture_en),
    .tx_strobe    (tx_strobe),
    .tx_data      (tx_data),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .byte_count   (byte_count),
    .overflow     (overflow),
    .capturing    (capturing)
  );

  // Model: mode 0 = idle, 1 = capturing, 2 = paused by upload.
  logic [7:0] mem_m [DEPTH];
  int         m_count = 0;
  bit         m_ovf = 1'b0;
  int         m_mode = 0;
  bit         m_last_cr = 1'b0;
  logic [7:0] m_din = 8'h00;
  bit         check_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      n_tests++;
      if (byte_count !== 16'(m_count) || overflow !== m_ovf ||
          capturing !== (m_mode == 1) || ioctl_din !== m_din) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t: count %0d exp %0d, ovf %0b exp %0b, cap %0b exp %0b, din %0h exp %0h",
                 $time, byte_count, m_count, overflow, m_ovf, capturing, (m_mode == 1), ioctl_din, m_din);
      end
    end
  end

  task automatic model_store(input logic [7:0] b);
    if (m_count < DEPTH) begin
      mem_m[m_count] = b;
      m_count++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_strobe(input logic [7:0] b);
    if (m_mode == 2) begin
      m_ovf = 1'b1;
    end else if (m_mode == 1) begin
`ifdef ASCII_SAVE_CRLF_EN
      if (b != 8'h00) begin
        bit lf_drop;
        lf_drop   = (b == 8'h0A) && m_last_cr;
        m_last_cr = (b == 8'h0D);
        if (!lf_drop) begin
          if (m_count < DEPTH) begin
            model_store(b);
            if (b == 8'h0D) model_store(8'h0A);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
`else
      model_store(b);
`endif
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    check_en = 1'b0;
    @(posedge clk); #1;
    tx_strobe = 1'b1;
    tx_data   = b;
    @(posedge clk); #1;
    tx_strobe = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    model_strobe(b);
    check_en = 1'b1;
    @(posedge clk);
  endtask

  task automatic set_cen(input bit v);
    check_en = 1'b0;
    @(posedge clk); #1;
    capture_en = v;
    repeat (3) @(posedge clk);
    #1;
    if (v && m_mode == 0) begin
      m_mode = 1; m_count = 0; m_ovf = 1'b0; m_last_cr = 1'b0;
    end else if (!v && m_mode == 1) begin
      m_mode = 0;
    end
    check_en = 1'b1;
  endtask

  task automatic set_upl(input bit v);
    check_en = 1'b0;
    @(posedge clk); #1;
    ioctl_upload = v;
    repeat (2) @(posedge clk);
    #1;
    if (v && m_mode == 1) m_mode = 2;
    else if (!v && m_mode == 2) m_mode = capture_en ? 1 : 0;
    check_en = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] a, output logic [7:0] got);
    logic [7:0] e;
    @(posedge clk); #1;
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    e = (int'(a) < m_count) ? mem_m[a[3:0]] : 8'h00;
    @(posedge clk); #1;
    ioctl_rd = 1'b0;
    m_din    = e;
    @(negedge clk);
    got = ioctl_din;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] sp [3];
    sp[0] = 8'h00; sp[1] = 8'h0A; sp[2] = 8'h0D;
    if ($urandom_range(0, 5) == 0) return sp[$urandom_range(0, 2)];
    return 8'($urandom);
  endfunction

  initial begin
    logic [7:0] got;
    logic [7:0] exp_a [5];

    // Reset values
    #2 n_reset = 1'b0;
    #20;
    chk("rst_din", ioctl_din, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cap", capturing, 0);
    n_reset = 1'b1;
    @(posedge clk); #1;
    check_en = 1'b1;

    // Capture "ABC" and read back with padding
    set_cen(1'b1);
    strobe(8'h41); strobe(8'h42); strobe(8'h43);
    @(negedge clk);
    chk("abc_cap", capturing, 1);
    chk("abc_count", byte_count, 3);
    exp_a[0] = 8'h41; exp_a[1] = 8'h42; exp_a[2] = 8'h43; exp_a[3] = 8'h00; exp_a[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      do_read(16'(i), got);
      chk($sformatf("abc_rd%0d", i), got, exp_a[i]);
    end
    do_read(16'h0010, got);
    chk("rd_beyond_cap", got, 0);

    // Fill past capacity, then re-arm
    set_cen(1'b0);
    set_cen(1'b1);
    for (int i = 0; i < 17; i++) strobe(8'(8'h60 + i));
    @(negedge clk);
    chk("full_count", byte_count, 16);
    chk("full_ovf", overflow, 1);
    do_read(16'd15, got);
    chk("full_rd15", got, 8'h6F);
    set_cen(1'b0);
    set_cen(1'b1);
    @(negedge clk);
    chk("rearm_ovf", overflow, 0);
    chk("rearm_count", byte_count, 0);

    // Strobe during upload pause is dropped
    strobe(8'h50); strobe(8'h51);
    set_upl(1'b1);
    strobe(8'h52);
    set_upl(1'b0);
    strobe(8'h53);
    @(negedge clk);
    chk("pause_count", byte_count, 3);
    chk("pause_ovf", overflow, 1);
    do_read(16'd2, got);
    chk("pause_rd2", got, 8'h53);

    // Strobes while idle are ignored; contents remain readable
    set_cen(1'b0);
    set_cen(1'b1);
    strobe(8'h61); strobe(8'h62); strobe(8'h63);
    set_cen(1'b0);
    for (int i = 0; i < 5; i++) strobe(8'(8'h70 + i));
    @(negedge clk);
    chk("idle_count", byte_count, 3);
    chk("idle_ovf", overflow, 0);
    chk("idle_cap", capturing, 0);
    do_read(16'd1, got);
    chk("idle_rd1", got, 8'h62);

    // Strobe in the same cycle the arm edge is detected lands at address 0
    check_en = 1'b0;
    @(posedge clk); #1;
    capture_en = 1'b1;
    @(posedge clk); #1;
    tx_strobe = 1'b1; tx_data = 8'h7A;
    @(posedge clk); #1;
    tx_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_mode = 1; m_count = 0; m_ovf = 1'b0; m_last_cr = 1'b0;
    model_strobe(8'h7A);
    check_en = 1'b1;
    @(negedge clk);
    chk("armstb_count", byte_count, 1);
    do_read(16'd0, got);
    chk("armstb_rd0", got, 8'h7A);

    // CR/LF handling
    set_cen(1'b0);
    set_cen(1'b1);
    strobe(8'h31); strobe(8'h0D); strobe(8'h00); strobe(8'h0A); strobe(8'h32);
    @(negedge clk);
`ifdef ASCII_SAVE_CRLF_EN
    chk("crlf_count", byte_count, 4);
    exp_a[0] = 8'h31; exp_a[1] = 8'h0D; exp_a[2] = 8'h0A; exp_a[3] = 8'h32; exp_a[4] = 8'h00;
`else
    chk("crlf_count", byte_count, 5);
    exp_a[0] = 8'h31; exp_a[1] = 8'h0D; exp_a[2] = 8'h00; exp_a[3] = 8'h0A; exp_a[4] = 8'h32;
`endif
    for (int i = 0; i < 5; i++) begin
      do_read(16'(i), got);
      chk($sformatf("crlf_rd%0d", i), got, exp_a[i]);
    end

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50) begin
        strobe(rand_byte());
      end else if (r < 75) begin
        if ($urandom_range(0, 3) == 0) do_read(16'($urandom), got);
        else do_read(16'($urandom_range(0, 20)), got);
      end else if (r < 87) begin
        set_upl(!ioctl_upload);
      end else if (capture_en) begin
        set_cen(1'b0);
      end else if (!ioctl_upload) begin
        set_cen(1'b1);
      end
    end

    // Asynchronous reset mid-capture
    if (ioctl_upload) set_upl(1'b0);
    if (!capture_en) set_cen(1'b1);
    else begin set_cen(1'b0); set_cen(1'b1); end
    strobe(8'h55); strobe(8'h56);
    do_read(16'd0, got);
    chk("prerst_rd0", got, 8'h55);
    check_en = 1'b0;
    @(posedge clk); #3;
    n_reset = 1'b0;
    #1;
    chk("arst_din", ioctl_din, 0);
    chk("arst_count", byte_count, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_cap", capturing, 0);
    capture_en = 1'b0;
    #7 n_reset = 1'b1;
    m_mode = 0; m_count = 0; m_ovf = 1'b0; m_din = 8'h00; m_last_cr = 1'b0;
    @(posedge clk); #1;
    check_en = 1'b1;
    strobe(8'h44);
    @(negedge clk);
    chk("postrst_count", byte_count, 0);
    chk("postrst_cap", capturing, 0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
